// File: rtl/lvds_tx_serializer_pkg.sv
// Shared LVDS pad configuration for the transmit serializer and the differential input path.
// Only the IO standard settings live here; word width and idle word stay with each instance.
package lvds_tx_serializer_pkg;

  localparam string LVDS_OUT_IOSTANDARD = "LVDS_33";
  localparam string LVDS_IN_IOSTANDARD  = "LVDS_33";

endpackage

// File: rtl/lvds_tx_serializer_if.sv
// Word handshake into the serializer: data/valid from upstream, ready marks the word boundary.
// ready is a boundary strobe only; it never stalls, so upstream must have data there or accept idle.
interface lvds_tx_serializer_if #(
  parameter int W = 8
) ();

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/lvds_tx_serializer_obuf.sv
// Differential output buffer wrapper (OBUFDS style): op follows i, on is its complement.
// Behavioral model; the vendor primitive replaces this body in the implementation flow.
module obuf_lvds
  import lvds_tx_serializer_pkg::*;
#(
  parameter string IOSTANDARD = LVDS_OUT_IOSTANDARD
) (
  input  logic i,
  output logic op,
  output logic on
);

  // Only a true differential standard makes sense on this pair.
  if (IOSTANDARD != "LVDS_33") begin : g_bad_std
    $error("obuf_lvds: unsupported IOSTANDARD");
  end

  assign op = i;
  assign on = ~i;

endmodule

// File: rtl/lvds_tx_serializer.sv
// MSB-first W:1 LVDS serializer with a frame pair marking each word's MSB; idle word fills gaps.
// Boundary every W clocks unconditionally; all pad drivers come straight from flops.
module lvds_tx_serializer
  import lvds_tx_serializer_pkg::*;
#(
  parameter int           W         = 8,
  parameter logic [W-1:0] IDLE_WORD = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  lvds_tx_serializer_if.slave       in_if,
  output logic                      underrun_o,
  output logic                      dp_o,
  output logic                      dn_o,
  output logic                      fp_o,
  output logic                      fn_o
);

  localparam int            CW       = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fr_q, fr_d;
  logic          underrun_q, underrun_d;
  logic          boundary;

  // Boundary depends on the counter alone so upstream sees ready regardless of valid.
  assign boundary    = (cnt_q == CNT_LAST);
  assign in_if.ready = boundary;

  always_comb begin
    cnt_d      = cnt_q + CW'(1);
    sr_d       = {sr_q[W-2:0], 1'b0};
    fr_d       = 1'b0;
    underrun_d = 1'b0;
    if (boundary) begin
      cnt_d      = '0;
      sr_d       = in_if.valid ? in_if.data : IDLE_WORD;
      fr_d       = 1'b1;
      underrun_d = ~in_if.valid;
    end
  end

  // Reset parks the counter on a boundary so the first edge afterwards can load a word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q       <= '0;
      cnt_q      <= CNT_LAST;
      fr_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      fr_q       <= fr_d;
      underrun_q <= underrun_d;
    end
  end

  assign underrun_o = underrun_q;

  obuf_lvds #(.IOSTANDARD(LVDS_OUT_IOSTANDARD)) u_obuf_data (
    .i  (sr_q[W-1]),
    .op (dp_o),
    .on (dn_o)
  );

  obuf_lvds #(.IOSTANDARD(LVDS_OUT_IOSTANDARD)) u_obuf_frame (
    .i  (fr_q),
    .op (fp_o),
    .on (fn_o)
  );

endmodule

// File: tb/tb_lvds_tx_serializer.sv
// Bench for lvds_tx_serializer: W=8 (idle 8'h3C) and W=2 instances against an edge-index stream model.
module tb_lvds_tx_serializer;

  localparam logic [7:0] IDLE8 = 8'h3C;
  localparam logic [1:0] IDLE2 = 2'b00;

  logic clk = 1'b0;
  logic rst8, rst2;
  logic un8, dp8, dn8, fp8, fn8;
  logic un2, dp2, dn2, fp2, fn2;

  always #5 clk = ~clk;

  lvds_tx_serializer_if #(.W(8)) if8 ();
  lvds_tx_serializer_if #(.W(2)) if2 ();

  lvds_tx_serializer #(.W(8), .IDLE_WORD(IDLE8)) dut8 (
    .clk_i(clk), .rst_i(rst8), .in_if(if8.slave),
    .underrun_o(un8), .dp_o(dp8), .dn_o(dn8), .fp_o(fp8), .fn_o(fn8)
  );

  lvds_tx_serializer #(.W(2), .IDLE_WORD(IDLE2)) dut2 (
    .clk_i(clk), .rst_i(rst2), .in_if(if2.slave),
    .underrun_o(un2), .dp_o(dp2), .dn_o(dn2), .fp_o(fp2), .fn_o(fn2)
  );

  int checks   = 0;
  int failures = 0;

  // Model: edges since reset release; every W-th edge (starting at 0) loads a word, which is then
  // emitted MSB-first one bit per edge.
  int          e8, e2;
  logic [7:0]  word8;
  logic [1:0]  word2;
  logic [31:0] cap8, cap2;
  int          fpc8, unc8, rdyc8, rdyc2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    cap8 = '0; cap2 = '0; fpc8 = 0; unc8 = 0; rdyc8 = 0; rdyc2 = 0;
  endtask

  task automatic reset8();
    rst8 = 1'b1; if8.valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst8_dp", {31'd0, dp8}, 0);
    chk("rst8_fp", {31'd0, fp8}, 0);
    chk("rst8_un", {31'd0, un8}, 0);
    #1 chk("rst8_ready", {31'd0, if8.ready}, 1);
    rst8 = 1'b0;
    e8 = 0;
  endtask

  task automatic step8(input logic v, input logic [7:0] d);
    int   ph;
    logic exp_un;
    logic rdy;
    ph = e8 % 8;
    if8.valid = v; if8.data = d;
    #1;
    rdy = if8.ready;
    chk("ready8", {31'd0, rdy}, {31'd0, ph == 0});
    @(posedge clk);
    exp_un = 1'b0;
    if (ph == 0) begin
      word8  = v ? d : IDLE8;
      exp_un = ~v;
    end
    e8++;
    @(negedge clk);
    chk("dp8", {31'd0, dp8}, {31'd0, word8[7-ph]});
    chk("dn8", {31'd0, dn8}, {31'd0, ~dp8});
    chk("fp8", {31'd0, fp8}, {31'd0, ph == 0});
    chk("fn8", {31'd0, fn8}, {31'd0, ~fp8});
    chk("un8", {31'd0, un8}, {31'd0, exp_un});
    cap8  = {cap8[30:0], dp8};
    fpc8 += int'(fp8);
    unc8 += int'(un8);
    rdyc8 += int'(rdy);
  endtask

  task automatic step2(input logic v, input logic [1:0] d);
    int   ph;
    logic exp_un;
    logic rdy;
    ph = e2 % 2;
    if2.valid = v; if2.data = d;
    #1;
    rdy = if2.ready;
    chk("ready2", {31'd0, rdy}, {31'd0, ph == 0});
    @(posedge clk);
    exp_un = 1'b0;
    if (ph == 0) begin
      word2  = v ? d : IDLE2;
      exp_un = ~v;
    end
    e2++;
    @(negedge clk);
    chk("dp2", {31'd0, dp2}, {31'd0, word2[1-ph]});
    chk("dn2", {31'd0, dn2}, {31'd0, ~dp2});
    chk("fp2", {31'd0, fp2}, {31'd0, ph == 0});
    chk("fn2", {31'd0, fn2}, {31'd0, ~fp2});
    chk("un2", {31'd0, un2}, {31'd0, exp_un});
    cap2  = {cap2[30:0], dp2};
    rdyc2 += int'(rdy);
  endtask

  initial begin
    rst8 = 1'b1; rst2 = 1'b1;
    if8.valid = 1'b0; if8.data = '0;
    if2.valid = 1'b0; if2.data = '0;
    e8 = 0; e2 = 0; word8 = '0; word2 = '0;
    clr_stats();
    @(negedge clk);

    // Single word A5 accepted at the first boundary after reset.
    reset8();
    clr_stats();
    step8(1'b1, 8'hA5);
    for (int i = 0; i < 7; i++) step8(1'b0, 8'(i));
    chk("a5_bits", {24'd0, cap8[7:0]}, 32'h0000_00A5);
    chk("a5_fp_count", fpc8, 1);
    chk("a5_underrun_count", unc8, 0);

    // Back-to-back FF, 00, 81 with valid held high.
    clr_stats();
    for (int w = 0; w < 3; w++) begin
      logic [7:0] wd;
      wd = (w == 0) ? 8'hFF : (w == 1) ? 8'h00 : 8'h81;
      for (int i = 0; i < 8; i++) step8(1'b1, wd);
    end
    chk("b2b_bits", {8'd0, cap8[23:0]}, 32'h00FF_0081);
    chk("b2b_ready_count", rdyc8, 3);
    chk("b2b_fp_count", fpc8, 3);
    chk("b2b_underrun_count", unc8, 0);

    // Idle insertion, then the following valid word.
    clr_stats();
    for (int i = 0; i < 8; i++) step8(1'b0, 8'hEE);
    chk("idle_bits", {24'd0, cap8[7:0]}, 32'h0000_003C);
    chk("idle_underrun_count", unc8, 1);
    for (int i = 0; i < 8; i++) step8(1'b1, 8'h96);
    chk("after_idle_bits", {24'd0, cap8[7:0]}, 32'h0000_0096);
    chk("after_idle_underrun_count", unc8, 1);

    // valid raised mid-word: the in-flight word is unaffected.
    clr_stats();
    step8(1'b1, 8'h0F);
    for (int i = 0; i < 2; i++) step8(1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step8(1'b1, 8'h55);
    chk("midword_bits", {24'd0, cap8[7:0]}, 32'h0000_000F);
    for (int i = 0; i < 8; i++) step8(1'b1, 8'h55);
    chk("midword_next_bits", {24'd0, cap8[7:0]}, 32'h0000_0055);

    // Reset during F0, then C3 starts cleanly from its MSB.
    step8(1'b1, 8'hF0);
    for (int i = 0; i < 4; i++) step8(1'b0, 8'h00);
    reset8();
    clr_stats();
    for (int i = 0; i < 8; i++) step8(1'b1, 8'hC3);
    chk("post_reset_bits", {24'd0, cap8[7:0]}, 32'h0000_00C3);
    chk("post_reset_fp_count", fpc8, 1);

    // Random traffic on the W=8 instance.
    for (int i = 0; i < 320; i++) step8($urandom_range(0, 3) != 0, 8'($urandom));

    // W=2 build: 10 then 01.
    rst2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst2_dp", {31'd0, dp2}, 0);
    chk("rst2_fp", {31'd0, fp2}, 0);
    #1 chk("rst2_ready", {31'd0, if2.ready}, 1);
    rst2 = 1'b0;
    e2 = 0;
    clr_stats();
    step2(1'b1, 2'b10); step2(1'b1, 2'b10);
    step2(1'b1, 2'b01); step2(1'b1, 2'b01);
    chk("w2_bits", {28'd0, cap2[3:0]}, 32'h0000_0009);
    chk("w2_ready_count", rdyc2, 2);
    for (int i = 0; i < 100; i++) step2($urandom_range(0, 2) != 0, 2'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lvds_tx_serializer.md
# lvds_tx_serializer

Parallel-to-serial LVDS transmitter: accepts W-bit words over a valid/ready handshake and shifts them out MSB-first at one bit per clock on a differential data pair, with a companion differential frame pair marking each word's MSB. It is the transmit-side counterpart of the single-ended-to-differential input path, and feeds board-level LVDS_33 links to downstream ADC/DAC/FPGA receivers. When no word is offered at a boundary, a fixed idle word is sent so the serial stream never stalls.

## Interface
- W, default 8: word width in bits; W >= 2.
- IDLE_WORD, default 0 (W bits): word transmitted when no input is valid at a word boundary.
- clock  input  1  sole clock; serial bit rate equals clock rate.
- reset  input  1  synchronous, active-high.
- data  input  W  word to transmit.
- valid  input  1  data is valid.
- ready  output  1  word boundary; a word is accepted on an edge where valid && ready.
- underrun  output  1  one-cycle pulse: IDLE_WORD was loaded because valid was low at a boundary.
- dp, dn  output  1 each  LVDS data pair.
- fp, fn  output  1 each  LVDS frame pair.

## Operation
- State: shift register sr (W bits), bit counter cnt (0..W-1, width clog2(W)), frame flop fr, underrun flop.
- Serial data = sr[W-1]; frame = fr; both registered, no combinational path to pads.
- ready = (cnt == W-1), combinational from cnt only; independent of valid.
- Every clock (not reset): if cnt == W-1: cnt <= 0; sr <= valid ? data : IDLE_WORD; fr <= 1; underrun <= !valid. Else: cnt <= cnt+1; sr <= sr << 1 (LSB filled with 0); fr <= 0; underrun <= 0.
- Words are back-to-back: no gap bits; boundary occurs every W cycles unconditionally.
- No backpressure from the pads; the upstream must present data at the boundary or accept an idle insertion.
- Reset (synchronous, any time, including mid-word): sr <= 0, cnt <= W-1, fr <= 0, underrun <= 0. The word in flight is discarded; no partial word resumes.

## Timing
- Reset values: serial data 0, frame 0, underrun 0, ready 1 (cnt = W-1).
- First edge after reset deasserts is a boundary: a word is accepted there if valid is high.
- Latency: word accepted at edge k → its MSB on serial data and fr=1 during cycle k..k+1; bit i (MSB = W-1) appears after edge k+(W-1-i); LSB leaves after edge k+W, which simultaneously loads the next word.
- underrun asserts in the same cycle as the idle word's MSB.
- ready is high for exactly one cycle in every W.
- Output buffers add only pad delay; no extra register stage.

## Structure
- Sub-module obuf_lvds (OBUFDS wrapper, IOSTANDARD "LVDS_33", ports i, op, on), instanced twice: data pair and frame pair.
- IO standard string lives in the shared config include alongside the input-buffer primitive's setting; no other shared constants or typedefs. W and IDLE_WORD stay local parameters.
- Simulation uses a behavioral OBUFDS model (op = i, on = ~i).

## Test plan
- Reset then valid=1, data=8'hA5 held at first boundary → dp sequence 1,0,1,0,0,1,0,1 over 8 cycles; fp high only on first bit; underrun 0; dn always ~dp.
- Back-to-back 8'hFF, 8'h00, 8'h81 with valid continuously high → 24 contiguous bits 11111111 00000000 10000001, ready pulses every 8 cycles, fp pulses every 8 cycles.
- valid low at a boundary, IDLE_WORD=8'h3C → bits 00111100 sent, underrun pulses once aligned with first idle bit; following valid word transmitted at next boundary.
- valid raised mid-word (cnt=3) with data=8'h55 → not accepted until ready; current word completes unchanged.
- reset asserted at cnt=4 of word 8'hF0 for one cycle → next cycle outputs 0/0, ready=1; after release, a new 8'hC3 is sent from MSB with fp=1; no remnant of 8'hF0.
- W=2 build, words 2'b10, 2'b01 → bits 1,0,0,1, ready high every other cycle.
